// File: rtl/seq_shift_register.sv
// Multi-function datapath register: clear/load/inc/dec in one cycle, plus a
// sequential one-bit-per-clock shift. Optional flags via SEQ_SHIFT_REGISTER_FLAGS_EN.
module seq_shift_register #(
    parameter int DATA_WIDTH = 16,
    parameter int AMT_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cl,
    input  logic                  ld,
    input  logic [DATA_WIDTH-1:0] in,
    input  logic                  inc,
    input  logic                  dec,
    input  logic                  start,
    input  logic                  dir,
    input  logic [1:0]            mode,
    input  logic [AMT_WIDTH-1:0]  amt,
    input  logic                  ser_in,
    output logic [DATA_WIDTH-1:0] out,
    output logic                  busy,
    output logic                  done,
    output logic                  ser_out
`ifdef SEQ_SHIFT_REGISTER_FLAGS_EN
    ,
    output logic                  zero,
    output logic                  neg
`endif
);

    localparam logic [1:0] MODE_LOG = 2'b00;
    localparam logic [1:0] MODE_ARI = 2'b01;
    localparam logic [1:0] MODE_ROT = 2'b10;

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    state_t                state_q, state_d;
    logic [AMT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  dir_q, dir_d;
    logic [1:0]            mode_q, mode_d;
    logic [DATA_WIDTH-1:0] out_q, out_d;
    logic                  ser_out_q, ser_out_d;
    logic                  done_q, done_d;

    logic                  fill;
    logic                  shift_bit;
    logic [DATA_WIDTH-1:0] shifted;

    // One-position shift using the direction/mode latched at start.
    always_comb begin
        fill      = 1'b0;
        shift_bit = 1'b0;
        shifted   = out_q;
        if (!dir_q) begin
            shift_bit = out_q[0];
            case (mode_q)
                MODE_LOG: fill = 1'b0;
                MODE_ARI: fill = out_q[DATA_WIDTH-1];
                MODE_ROT: fill = out_q[0];
                default:  fill = ser_in;
            endcase
            shifted = {fill, out_q[DATA_WIDTH-1:1]};
        end else begin
            shift_bit = out_q[DATA_WIDTH-1];
            case (mode_q)
                MODE_LOG: fill = 1'b0;
                MODE_ARI: fill = 1'b0;
                MODE_ROT: fill = out_q[DATA_WIDTH-1];
                default:  fill = ser_in;
            endcase
            shifted = {out_q[DATA_WIDTH-2:0], fill};
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dir_d     = dir_q;
        mode_d    = mode_q;
        out_d     = out_q;
        ser_out_d = ser_out_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (cl) begin
                    out_d     = '0;
                    ser_out_d = 1'b0;
                end else if (ld) begin
                    out_d = in;
                end else if (inc) begin
                    out_d = out_q + DATA_WIDTH'(1);
                end else if (dec) begin
                    out_d = out_q - DATA_WIDTH'(1);
                end else if (start) begin
                    dir_d  = dir;
                    mode_d = mode;
                    cnt_d  = amt;
                    if (amt == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                // Clear aborts the shift without a completion pulse.
                if (cl) begin
                    out_d     = '0;
                    ser_out_d = 1'b0;
                    cnt_d     = '0;
                    state_d   = IDLE;
                end else begin
                    out_d     = shifted;
                    ser_out_d = shift_bit;
                    cnt_d     = cnt_q - AMT_WIDTH'(1);
                    if (cnt_q == AMT_WIDTH'(1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            dir_q     <= 1'b0;
            mode_q    <= MODE_LOG;
            out_q     <= '0;
            ser_out_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dir_q     <= dir_d;
            mode_q    <= mode_d;
            out_q     <= out_d;
            ser_out_q <= ser_out_d;
            done_q    <= done_d;
        end
    end

    assign out     = out_q;
    assign busy    = (state_q == SHIFT);
    assign done    = done_q;
    assign ser_out = ser_out_q;

`ifdef SEQ_SHIFT_REGISTER_FLAGS_EN
    assign zero = (out_q == '0);
    assign neg  = out_q[DATA_WIDTH-1];
`endif

endmodule

// File: tb/tb_seq_shift_register.sv
// Directed bench for seq_shift_register: commands, shift modes, abort and
// asynchronous reset, with hand-computed expected values.
module tb_seq_shift_register;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cl, ld, inc, dec, start, dir, ser_in;
    logic [1:0]  mode;
    logic [3:0]  amt;
    logic [15:0] in;
    logic [15:0] out;
    logic        busy, done, ser_out;
`ifdef SEQ_SHIFT_REGISTER_FLAGS_EN
    logic        zero, neg;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    seq_shift_register #(.DATA_WIDTH(16), .AMT_WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .cl(cl), .ld(ld), .in(in), .inc(inc),
        .dec(dec), .start(start), .dir(dir), .mode(mode), .amt(amt),
        .ser_in(ser_in), .out(out), .busy(busy), .done(done),
        .ser_out(ser_out)
`ifdef SEQ_SHIFT_REGISTER_FLAGS_EN
        , .zero(zero), .neg(neg)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cl = 0; ld = 0; inc = 0; dec = 0; start = 0;
    endtask

    task automatic check_all(input string tag, input logic [15:0] e_out,
                             input logic e_busy, input logic e_done, input logic e_ser);
        check({tag, ".out"}, 32'(out), 32'(e_out));
        check({tag, ".busy"}, 32'(busy), 32'(e_busy));
        check({tag, ".done"}, 32'(done), 32'(e_done));
        check({tag, ".ser_out"}, 32'(ser_out), 32'(e_ser));
        $display("step %-14s out=0x%04h busy=%0b done=%0b ser_out=%0b", tag, out, busy, done, ser_out);
    endtask

    initial begin
        rst_n = 0; idle_inputs(); dir = 0; mode = 0; amt = 0; in = 0; ser_in = 0;
        #12;
        check_all("reset", 16'h0000, 0, 0, 0);
        rst_n = 1;

        // Right arithmetic by 3.
        ld = 1; in = 16'h8001; step(); idle_inputs();
        check_all("t1.ld", 16'h8001, 0, 0, 0);
        start = 1; dir = 0; mode = 2'b01; amt = 3; step(); idle_inputs();
        check_all("t1.E0", 16'h8001, 1, 0, 0);
        step(); check_all("t1.E1", 16'hC000, 1, 0, 1);
        step(); check_all("t1.E2", 16'hE000, 1, 0, 0);
        step(); check_all("t1.E3", 16'hF000, 0, 1, 0);
        // Back-to-back start in the done cycle: left logical by 1.
        start = 1; dir = 1; mode = 2'b00; amt = 1; step(); idle_inputs();
        check_all("b2b.E0", 16'hF000, 1, 0, 0);
        step(); check_all("b2b.E1", 16'hE000, 0, 1, 1);
        step(); check_all("b2b.after", 16'hE000, 0, 0, 1);

        // Left rotate by 4, with commands and config changes ignored mid-shift.
        ld = 1; in = 16'h8001; step(); idle_inputs();
        start = 1; dir = 1; mode = 2'b10; amt = 4; step(); idle_inputs();
        check_all("t2.E0", 16'h8001, 1, 0, 1);
        ld = 1; inc = 1; start = 1; in = 16'hFFFF; dir = 0; mode = 2'b00; amt = 1;
        step(); idle_inputs();
        check_all("t2.E1", 16'h0003, 1, 0, 1);
        step(); check_all("t2.E2", 16'h0006, 1, 0, 0);
        step(); check_all("t2.E3", 16'h000C, 1, 0, 0);
        step(); check_all("t2.E4", 16'h0018, 0, 1, 0);
        step(); check_all("t2.after", 16'h0018, 0, 0, 0);

        // Zero-amount shift.
        ld = 1; in = 16'h1234; step(); idle_inputs();
        start = 1; amt = 0; step(); idle_inputs();
        check_all("t3.E0", 16'h1234, 0, 1, 0);
        step(); check_all("t3.after", 16'h1234, 0, 0, 0);

        // Serial left by 8, aborted by clear after two shifts.
        ld = 1; in = 16'h0000; step(); idle_inputs();
        start = 1; dir = 1; mode = 2'b11; amt = 8; ser_in = 1; step(); idle_inputs();
        step(); check_all("t4.E1", 16'h0001, 1, 0, 0);
        step(); check_all("t4.E2", 16'h0003, 1, 0, 0);
        cl = 1; step(); idle_inputs();
        check_all("t4.cl", 16'h0000, 0, 0, 0);
        step(); check_all("t4.after", 16'h0000, 0, 0, 0);
        ser_in = 0;

        // Right logical by 1 sets ser_out, idle clear resets it.
        ld = 1; in = 16'h0001; step(); idle_inputs();
        start = 1; dir = 0; mode = 2'b00; amt = 1; step(); idle_inputs();
        step(); check_all("t5.E1", 16'h0000, 0, 1, 1);
        ld = 1; in = 16'h00F0; step(); idle_inputs();
        check_all("t5.ld_keep_ser", 16'h00F0, 0, 0, 1);
        cl = 1; step(); idle_inputs();
        check_all("t5.cl", 16'h0000, 0, 0, 0);

        // Wrap and priority.
        ld = 1; in = 16'hFFFF; step(); idle_inputs();
        inc = 1; step(); idle_inputs();
        check_all("t6.inc_wrap", 16'h0000, 0, 0, 0);
        dec = 1; step(); idle_inputs();
        check_all("t6.dec_wrap", 16'hFFFF, 0, 0, 0);
        ld = 1; inc = 1; in = 16'h00AA; step(); idle_inputs();
        check_all("t6.ld_over_inc", 16'h00AA, 0, 0, 0);
        inc = 1; dec = 1; step(); idle_inputs();
        check_all("t6.inc_over_dec", 16'h00AB, 0, 0, 0);
        cl = 1; ld = 1; step(); idle_inputs();
        check_all("t6.cl_over_ld", 16'h0000, 0, 0, 0);

        // Asynchronous reset mid-shift.
        ld = 1; in = 16'h5555; step(); idle_inputs();
        start = 1; dir = 0; mode = 2'b00; amt = 15; step(); idle_inputs();
        step(); check_all("t7.E1", 16'h2AAA, 1, 0, 1);
        rst_n = 0; #1;
        check_all("t7.rst", 16'h0000, 0, 0, 0);
        #1; rst_n = 1;
        step(); check_all("t7.idle", 16'h0000, 0, 0, 0);
        ld = 1; in = 16'hBEEF; step(); idle_inputs();
        check_all("t7.ld", 16'hBEEF, 0, 0, 0);
        repeat (15) begin
            step();
            check("t7.no_done", 32'(done), 32'(0));
        end
        check("t7.hold", 32'(out), 32'h0000BEEF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/seq_shift_register.md
Name: seq_shift_register

Overview:
- Next-generation multi-function datapath register for the picoComputer CPU.
- Keeps single-cycle clear, load, increment and decrement.
- Adds a multi-bit shift run sequentially, one bit per clock, with a start/busy/done handshake.
- Shift modes: logical, arithmetic, rotate and serial-in.
- Sits where the accumulator and general registers need shift-by-N instructions without a barrel shifter.

Parameters:
- DATA_WIDTH, 16, register width in bits (>= 2).
- AMT_WIDTH, 4, width of the shift-amount input; maximum shift is 2^AMT_WIDTH - 1.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- cl  input  1  synchronous clear of out.
- ld  input  1  load out from in.
- in  input  DATA_WIDTH  load data.
- inc  input  1  out <= out + 1.
- dec  input  1  out <= out - 1.
- start  input  1  begin a shift operation.
- dir  input  1  shift direction: 0 = right, 1 = left.
- mode  input  2  fill mode: 00 logical, 01 arithmetic, 10 rotate, 11 serial.
- amt  input  AMT_WIDTH  number of bit positions to shift.
- ser_in  input  1  fill bit for serial mode.
- out  output  DATA_WIDTH  register contents.
- busy  output  1  high while a shift is in progress.
- done  output  1  one-cycle pulse when a shift completes.
- ser_out  output  1  last bit shifted out.

Behaviour:
- Reset: rst_n low forces out = 0, busy = 0, done = 0, ser_out = 0, state IDLE and counter 0, immediately and regardless of clk. This holds mid-shift too: the shift is abandoned and no done pulse is produced.
- States: IDLE and SHIFT. done is registered and high for exactly one cycle; otherwise 0.
- IDLE priority on each edge: cl > ld > inc > dec > start. Only the highest-priority asserted command acts.
  - cl: out <= 0, ser_out <= 0.
  - ld: out <= in.
  - inc, dec: out wraps modulo 2^DATA_WIDTH (0xFFFF+1 = 0x0000, 0x0000-1 = 0xFFFF).
  - ld, inc and dec leave ser_out unchanged.
- start in IDLE (edge E0):
  - Latch dir and mode; load the counter with amt. out is unchanged at E0.
  - amt = 0: stay in IDLE, busy stays 0, done = 1 in the cycle after E0, out and ser_out unchanged.
  - amt = k > 0: go to SHIFT with busy = 1.
- SHIFT:
  - On each of edges E1..Ek, shift out by one position and decrement the counter.
  - On edge Ek, go to IDLE with busy = 0 and done = 1. The final value is visible after Ek, so latency is k cycles from the start edge.
- Per-bit shift, right (dir = 0):
  - The bit leaving is out[0], and it goes to ser_out.
  - Fill for out[MSB]: 0 (logical), out[MSB] (arithmetic), out[0] (rotate), ser_in (serial).
- Per-bit shift, left (dir = 1):
  - The bit leaving is out[MSB], and it goes to ser_out.
  - Fill for out[0]: 0 (logical and arithmetic), out[MSB] (rotate), ser_in (serial).
- ser_in is sampled on every shift edge, not latched at start.
- During SHIFT:
  - ld, inc, dec and start are ignored.
  - cl aborts: out <= 0, ser_out <= 0, busy <= 0, return to IDLE, no done pulse.
  - dir, mode and amt changes have no effect on the operation in progress.
- A new start may be issued in the cycle done is high, because the state is already IDLE.

Optional Feature:
- Macro: SEQ_SHIFT_REGISTER_FLAGS_EN.
- Defined: adds output ports zero (1, high when out == 0) and neg (1, equal to out[DATA_WIDTH-1]). Both are combinational from out, so both read 1/0 after reset.
- Undefined: these ports do not exist; all other behaviour is identical.

Test Plan:
- ld 0x8001, then start dir=0 mode=01 amt=3 -> busy high for 3 cycles; after E3 out = 0xF000, ser_out = 0, done pulses once.
- ld 0x8001, then start dir=1 mode=10 amt=4 -> after E4 out = 0x0018, ser_out = 0, busy deasserts in the same cycle done = 1.
- ld 0x1234, start amt=0 -> done = 1 next cycle, busy never 1, out = 0x1234.
- ld 0x0000, start dir=1 mode=11 amt=8 with ser_in=1 -> after 2 shift cycles assert cl -> out = 0x0000, busy = 0, ser_out = 0, no done pulse.
- ld 0xFFFF, inc -> 0x0000; dec -> 0xFFFF; ld=1 and inc=1 with in=0x00AA -> out = 0x00AA; cl=1 and ld=1 -> 0x0000.
- Mid-shift (amt=15), pulse rst_n low between edges -> out, busy, done and ser_out are 0 immediately; after release, the IDLE load works normally.
